// File: rtl/alu_op_issue_if.sv
// Handshake bundle between the register-read stage, the ALU issue stage and the execute stage.
interface alu_op_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [2:0]  ALUControl;
  logic [4:0]  RdOut;
  logic        IllegalOp;

  modport slave (
    input  in_valid, Instr, PC, RD1, RD2, out_ready,
    output in_ready, out_valid, SrcA, SrcB, ALUControl, RdOut, IllegalOp
  );

  modport master (
    output in_valid, Instr, PC, RD1, RD2, out_ready,
    input  in_ready, out_valid, SrcA, SrcB, ALUControl, RdOut, IllegalOp
  );
endinterface

// File: rtl/alu_op_issue.sv
// ALU issue stage: decodes an RV32 instruction into ALU operands/control and
// presents it through a registered two-entry (main + skid) output buffer.
module alu_op_issue (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          Flush,
  alu_op_issue_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SRA = 3'b110,
    ALU_XOR = 3'b111
  } alu_ctrl_e;

  typedef struct packed {
    logic [31:0] src_a;
    logic [31:0] src_b;
    alu_ctrl_e   ctrl;
    logic [4:0]  rd;
    logic        illegal;
  } issue_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_MAIN  = 2'b01,
    BUF_FULL  = 2'b10
  } buf_state_e;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  logic        legal;
  alu_ctrl_e   ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  issue_t      decoded;

  buf_state_e  state;
  buf_state_e  state_next;
  issue_t      main_q;
  issue_t      skid_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        in_ready_next;
  logic        out_valid_next;
  logic        load_main;
  logic        load_skid;
  logic        promote;
  logic        push;
  logic        pop;

  assign opcode = bus.Instr[6:0];
  assign funct3 = bus.Instr[14:12];
  assign funct7 = bus.Instr[31:25];
  assign imm_i  = {{20{bus.Instr[31]}}, bus.Instr[31:20]};
  assign imm_s  = {{20{bus.Instr[31]}}, bus.Instr[31:25], bus.Instr[11:7]};
  assign imm_u  = {bus.Instr[31:12], 12'b0};
  assign shamt  = {27'b0, bus.Instr[24:20]};

  // Operand selection defaults to the I-type shape (RD1, I-imm); other formats override.
  always_comb begin
    legal = 1'b0;
    ctrl  = ALU_ADD;
    op_a  = bus.RD1;
    op_b  = imm_i;
    case (opcode)
      OP_R: begin
        op_b = bus.RD2;
        case (funct3)
          3'b000: begin
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            ctrl  = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          end
          3'b001: begin
            legal = (funct7 == F7_BASE);
            ctrl  = ALU_SLL;
          end
          3'b100: begin
            legal = (funct7 == F7_BASE);
            ctrl  = ALU_XOR;
          end
          3'b101: begin
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            ctrl  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          end
          3'b110: begin
            legal = (funct7 == F7_BASE);
            ctrl  = ALU_OR;
          end
          3'b111: begin
            legal = (funct7 == F7_BASE);
            ctrl  = ALU_AND;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_IMM: begin
        case (funct3)
          3'b000: begin
            legal = 1'b1;
            ctrl  = ALU_ADD;
          end
          3'b001: begin
            legal = (funct7 == F7_BASE);
            ctrl  = ALU_SLL;
            op_b  = shamt;
          end
          3'b100: begin
            legal = 1'b1;
            ctrl  = ALU_XOR;
          end
          3'b101: begin
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            ctrl  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            op_b  = shamt;
          end
          3'b110: begin
            legal = 1'b1;
            ctrl  = ALU_OR;
          end
          3'b111: begin
            legal = 1'b1;
            ctrl  = ALU_AND;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_LOAD, OP_JALR: legal = 1'b1;
      OP_STORE: begin
        legal = 1'b1;
        op_b  = imm_s;
      end
      OP_LUI: begin
        legal = 1'b1;
        op_a  = 32'b0;
        op_b  = imm_u;
      end
      OP_AUIPC: begin
        legal = 1'b1;
        op_a  = bus.PC;
        op_b  = imm_u;
      end
      OP_BRANCH: begin
        legal = (funct3 == 3'b000) || (funct3 == 3'b001);
        ctrl  = ALU_SUB;
        op_b  = bus.RD2;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal instructions still travel down the pipe, but with zeroed operands.
  always_comb begin
    decoded    = '0;
    decoded.rd = bus.Instr[11:7];
    if (legal) begin
      decoded.src_a = op_a;
      decoded.src_b = op_b;
      decoded.ctrl  = ctrl;
    end else begin
      decoded.illegal = 1'b1;
    end
  end

  assign push = bus.in_valid && in_ready_q && !Flush;
  assign pop  = out_valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BUF_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      in_ready_q  <= in_ready_next;
      out_valid_q <= out_valid_next;
    end
  end

  // in_ready/out_valid are precomputed from the next occupancy so both leave as flops.
  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    promote    = 1'b0;
    if (Flush) begin
      state_next = BUF_EMPTY;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (push) begin
            state_next = BUF_MAIN;
            load_main  = 1'b1;
          end
        end
        BUF_MAIN: begin
          if (push && pop) begin
            load_main = 1'b1;
          end else if (push) begin
            state_next = BUF_FULL;
            load_skid  = 1'b1;
          end else if (pop) begin
            state_next = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (pop) begin
            state_next = BUF_MAIN;
            promote    = 1'b1;
          end
        end
        default: state_next = BUF_EMPTY;
      endcase
    end
    in_ready_next  = (state_next != BUF_FULL);
    out_valid_next = (state_next != BUF_EMPTY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (promote) begin
        main_q <= skid_q;
      end else if (load_main) begin
        main_q <= decoded;
      end
      if (load_skid) begin
        skid_q <= decoded;
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.SrcA       = main_q.src_a;
  assign bus.SrcB       = main_q.src_b;
  assign bus.ALUControl = main_q.ctrl;
  assign bus.RdOut      = main_q.rd;
  assign bus.IllegalOp  = main_q.illegal;

endmodule

// File: tb/tb_alu_op_issue.sv
// Testbench for alu_op_issue: directed decode/buffer scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_alu_op_issue;

  logic clk = 1'b0;
  logic reset_n;
  logic Flush;

  alu_op_issue_if bus ();

  alu_op_issue dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Flush   (Flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctl;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t model_q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   deliveries = 0;

  // Reference decode written from the instruction-set rules, with plain integer sign extension.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] rd1, input logic [31:0] rd2);
    exp_t       e;
    logic       ok;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    int         imm_i;
    int         imm_s;
    op    = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    imm_i = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
    imm_s = int'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0);
    e     = '0;
    ok    = 1'b0;
    e.a   = rd1;
    e.b   = 32'(imm_i);
    case (op)
      7'h33: begin
        e.b = rd2;
        if (f7 == 7'h00 && f3 != 3'd2 && f3 != 3'd3) begin
          ok    = 1'b1;
          e.ctl = (f3 == 3'd0) ? 3'd0 : (f3 == 3'd7) ? 3'd2 : (f3 == 3'd6) ? 3'd3 :
                  (f3 == 3'd1) ? 3'd4 : (f3 == 3'd5) ? 3'd5 : 3'd7;
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          ok    = 1'b1;
          e.ctl = 3'd1;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          ok    = 1'b1;
          e.ctl = 3'd6;
        end
      end
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.b = 32'(ins[24:20]);
          if (f7 == 7'h00) begin
            ok    = 1'b1;
            e.ctl = (f3 == 3'd1) ? 3'd4 : 3'd5;
          end else if (f7 == 7'h20 && f3 == 3'd5) begin
            ok    = 1'b1;
            e.ctl = 3'd6;
          end
        end else if (f3 != 3'd2 && f3 != 3'd3) begin
          ok    = 1'b1;
          e.ctl = (f3 == 3'd0) ? 3'd0 : (f3 == 3'd7) ? 3'd2 : (f3 == 3'd6) ? 3'd3 : 3'd7;
        end
      end
      7'h03, 7'h67: ok = 1'b1;
      7'h23: begin
        ok  = 1'b1;
        e.b = 32'(imm_s);
      end
      7'h37: begin
        ok  = 1'b1;
        e.a = 32'h0;
        e.b = ins & 32'hFFFF_F000;
      end
      7'h17: begin
        ok  = 1'b1;
        e.a = pc;
        e.b = ins & 32'hFFFF_F000;
      end
      7'h63: begin
        e.b = rd2;
        if (f3 == 3'd0 || f3 == 3'd1) begin
          ok    = 1'b1;
          e.ctl = 3'd1;
        end
      end
      default: ok = 1'b0;
    endcase
    e.rd = ins[11:7];
    if (!ok) begin
      e.a   = 32'h0;
      e.b   = 32'h0;
      e.ctl = 3'd0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h33;
      2: w[6:0] = 7'h13;
      3: w[6:0] = 7'h13;
      4: w[6:0] = 7'h03;
      5: w[6:0] = 7'h67;
      6: w[6:0] = 7'h23;
      7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;
      default: w[6:0] = ($urandom_range(0, 1) == 0) ? 7'h63 : w[6:0];
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: w[31:25] = w[31:25];
    endcase
    return w;
  endfunction

  function automatic logic [95:0] dut_pack();
    return 96'({bus.SrcA, bus.SrcB, bus.ALUControl, bus.RdOut, bus.IllegalOp});
  endfunction

  task automatic check_output(input string name, input logic [95:0] actual, input logic [95:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update: occupancy before the edge decides acceptance, exactly like a registered ready.
  always @(posedge clk or negedge reset_n) begin : model_update
    bit do_push;
    bit do_pop;
    if (!reset_n) begin
      model_q.delete();
    end else begin
      do_push = bus.in_valid && (model_q.size() < 2) && !Flush;
      do_pop  = (model_q.size() > 0) && bus.out_ready;
      if (Flush) begin
        model_q.delete();
      end else begin
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(ref_decode(bus.Instr, bus.PC, bus.RD1, bus.RD2));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      check_output("reset_out_valid", 96'(bus.out_valid), 96'(0));
      check_output("reset_in_ready", 96'(bus.in_ready), 96'(1));
      check_output("reset_data", dut_pack(), 96'(0));
    end else begin
      check_output("in_ready", 96'(bus.in_ready), 96'(model_q.size() < 2));
      check_output("out_valid", 96'(bus.out_valid), 96'(model_q.size() > 0));
      if (model_q.size() > 0) check_output("out_data", dut_pack(), 96'(model_q[0]));
      if (bus.out_valid && bus.out_ready) deliveries++;
    end
  end

  task automatic apply_stimulus(input logic [31:0] ins, input logic [31:0] pc,
                                input logic [31:0] rd1, input logic [31:0] rd2, output int waited);
    bus.Instr    = ins;
    bus.PC       = pc;
    bus.RD1      = rd1;
    bus.RD2      = rd2;
    bus.in_valid = 1'b1;
    waited       = 0;
    for (;;) begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 40) begin
        check_output("accept_timeout", 96'(waited), 96'(0));
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_and_check(input string name, input logic [31:0] ins, input logic [31:0] pc,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic ill);
    int w;
    apply_stimulus(ins, pc, rd1, rd2, w);
    @(negedge clk);
    check_output(name, 96'({bus.out_valid, bus.SrcA, bus.SrcB, bus.ALUControl, bus.RdOut, bus.IllegalOp}),
                 96'({1'b1, a, b, ctl, rd, ill}));
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int w;
    int stalls;
    int start_cnt;
    reset_n       = 1'b0;
    Flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.Instr     = 32'h0;
    bus.PC        = 32'h0;
    bus.RD1       = 32'h0;
    bus.RD2       = 32'h0;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.Instr     = $urandom;
      bus.PC        = $urandom;
      bus.RD1       = $urandom;
      bus.RD2       = $urandom;
    end
    @(negedge clk);
    check_output("rst_lit", 96'({bus.out_valid, bus.in_ready, bus.SrcA, bus.SrcB, bus.ALUControl, bus.RdOut, bus.IllegalOp}),
                 96'({1'b0, 1'b1, 73'b0}));
    @(posedge clk);
    #3;
    reset_n       = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] first add after reset and decode sweep");
    send_and_check("add_x",  32'h0020_8033, 32'h0,   32'd5,        32'd7,    3'b000, 32'd5,        32'd7,         5'd0, 1'b0);
    send_and_check("sub",    32'h4020_81B3, 32'h0,   32'd20,       32'd6,    3'b001, 32'd20,       32'd6,         5'd3, 1'b0);
    send_and_check("sra",    32'h4020_D1B3, 32'h0,   32'h8000_0000, 32'd4,   3'b110, 32'h8000_0000, 32'd4,        5'd3, 1'b0);
    send_and_check("srai",   32'h4030_D093, 32'h0,   32'hF0,       32'h55,   3'b110, 32'hF0,       32'd3,         5'd1, 1'b0);
    send_and_check("lui",    32'h1234_52B7, 32'h0,   32'd9,        32'd9,    3'b000, 32'h0,        32'h1234_5000, 5'd5, 1'b0);
    send_and_check("auipc",  32'h0000_1297, 32'h100, 32'd9,        32'd9,    3'b000, 32'h100,      32'h1000,      5'd5, 1'b0);
    send_and_check("sw",     32'h0020_A423, 32'h0,   32'h40,       32'd1,    3'b000, 32'h40,       32'd8,         5'd8, 1'b0);
    send_and_check("beq",    32'h0020_8463, 32'h0,   32'd3,        32'd4,    3'b001, 32'd3,        32'd4,         5'd8, 1'b0);
    send_and_check("addi_m1", 32'hFFF0_8093, 32'h0,  32'd1,        32'd2,    3'b000, 32'd1,        32'hFFFF_FFFF, 5'd1, 1'b0);
    send_and_check("ill_slt", 32'h0020_A1B3, 32'h0,  32'd11,       32'd12,   3'b000, 32'h0,        32'h0,         5'd3, 1'b1);
    send_and_check("ill_mul", 32'h0220_81B3, 32'h0,  32'd11,       32'd12,   3'b000, 32'h0,        32'h0,         5'd3, 1'b1);
    send_and_check("ill_blt", 32'h0020_C463, 32'h0,  32'd11,       32'd12,   3'b000, 32'h0,        32'h0,         5'd8, 1'b1);
    send_and_check("ill_7f",  32'h0000_007F, 32'h0,  32'd11,       32'd12,   3'b000, 32'h0,        32'h0,         5'd0, 1'b1);

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    apply_stimulus(32'h0020_8033, 32'h0, 32'h11, 32'h1, w);
    apply_stimulus(32'h0020_8033, 32'h0, 32'h22, 32'h2, w);
    bus.Instr    = 32'h0020_8033;
    bus.RD1      = 32'h33;
    bus.RD2      = 32'h3;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check_output("bp_full", 96'({bus.in_ready, bus.out_valid, bus.SrcA}), 96'({1'b0, 1'b1, 32'h11}));
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("bp_hold", 96'({bus.in_ready, bus.out_valid, bus.SrcA}), 96'({1'b0, 1'b1, 32'h11}));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("bp_second", 96'({bus.in_ready, bus.out_valid, bus.SrcA}), 96'({1'b1, 1'b1, 32'h22}));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_output("bp_third", 96'({bus.out_valid, bus.SrcA}), 96'({1'b1, 32'h33}));
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("bp_drained", 96'({bus.out_valid, bus.in_ready}), 96'({1'b0, 1'b1}));
    @(posedge clk);
    #1;

    $display("[TB] full throughput");
    stalls    = 0;
    start_cnt = deliveries;
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(32'h0020_8033 | (32'(i) << 7), 32'h0, 32'(i), 32'(i * 3), w);
      stalls += w;
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    check_output("thru_count", 96'(deliveries - start_cnt), 96'(16));
    check_output("thru_stalls", 96'(stalls), 96'(0));

    $display("[TB] flush");
    bus.out_ready = 1'b0;
    apply_stimulus(32'h0020_8033, 32'h0, 32'hA1, 32'h1, w);
    apply_stimulus(32'h0020_8033, 32'h0, 32'hA2, 32'h2, w);
    bus.Instr    = 32'h0020_8033;
    bus.RD1      = 32'hA3;
    bus.in_valid = 1'b1;
    Flush        = 1'b1;
    @(posedge clk);
    #1;
    Flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_output("flush_empty", 96'({bus.out_valid, bus.in_ready}), 96'({1'b0, 1'b1}));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    start_cnt     = deliveries;
    repeat (4) @(posedge clk);
    #1;
    check_output("flush_no_output", 96'(deliveries - start_cnt), 96'(0));

    $display("[TB] random traffic");
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.Instr     = rand_instr();
      bus.PC        = $urandom;
      bus.RD1       = $urandom;
      bus.RD2       = $urandom;
      if (((cyc / 100) % 3) == 2) bus.out_ready = ($urandom_range(0, 7) == 0);
      else                        bus.out_ready = ($urandom_range(0, 2) != 0);
      Flush = ($urandom_range(0, 39) == 0);
      if (cyc == 1500) reset_n = 1'b0;
      if (cyc == 1503) reset_n = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    Flush         = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check_output("final_idle", 96'({bus.out_valid, bus.in_ready}), 96'({1'b0, 1'b1}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
# alu_op_issue

Issue stage that drives the ALU's operand and control inputs. Accepts one decoded-register-read instruction per cycle over a valid/ready handshake, decodes opcode/funct3/funct7 into the 3-bit ALUControl code, and selects and extends SrcA/SrcB. Results are presented registered on a valid/ready output, with a two-entry skid buffer so that in_ready is a pure register output. Sits between the register-file read stage and the ALU/execute stage.

## Interface
- No parameters. Widths are fixed: XLEN 32, ALUControl 3.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- Flush  in  1  synchronous; discards all buffered and incoming transactions
- in_valid  in  1  upstream transaction present
- in_ready  out  1  block can accept; registered
- Instr  in  32  raw instruction word
- PC  in  32  instruction address
- RD1  in  32  rs1 read data
- RD2  in  32  rs2 read data
- out_valid  out  1  SrcA/SrcB/ALUControl/RdOut/IllegalOp valid
- out_ready  in  1  execute stage can accept
- SrcA  out  32  ALU operand A
- SrcB  out  32  ALU operand B
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 sll, 101 srl, 110 sra, 111 xor
- RdOut  out  5  Instr[11:7] passed through
- IllegalOp  out  1  instruction not executable on this ALU

## Operation
- Input handshake fires when in_valid && in_ready && !Flush. Output handshake fires when out_valid && out_ready.
- Decode is combinational on the input side. All outputs are taken from registers.
- R-type (0110011). SrcA=RD1, SrcB=RD2.
  - Legal pairs (funct3/funct7): 000/0000000 add; 000/0100000 sub; 111/0 and; 110/0 or; 001/0 sll; 101/0 srl; 101/0100000 sra; 100/0 xor.
- I-type ALU (0010011). SrcA=RD1, SrcB=sign-extended Instr[31:20].
  - Legal funct3: 000 add, 111 and, 110 or, 100 xor.
  - Shifts: 001 requires Instr[31:25]=0 (sll). 101 requires Instr[31:25]=0 (srl) or 0100000 (sra). For shifts, SrcB = zero-extended Instr[24:20].
- Load (0000011), JALR (1100111): add, SrcA=RD1, SrcB=I-imm.
- Store (0100011): add, SrcA=RD1, SrcB=sign-extended {Instr[31:25],Instr[11:7]}.
- LUI (0110111): add, SrcA=0, SrcB={Instr[31:12],12'b0}.
- AUIPC (0010111): add, SrcA=PC, SrcB=U-imm.
- Branch (1100011): funct3 000/001 give sub, SrcA=RD1, SrcB=RD2.
- Everything else is illegal. This includes slt/sltu (funct3 010/011), any other funct7 (including 0000001), other branch funct3 values, and unknown opcodes.
- Illegal instructions still produce one output transaction: IllegalOp=1, ALUControl=000, SrcA=SrcB=0, RdOut passed through.
- Buffer holds a main entry (drives outputs) and a skid entry.
  - in_ready = !skid_valid.
  - Accept while main is empty, or main is draining this cycle: the item goes to main.
  - Accept while main is full and not draining: the item goes to skid.
  - Main drains while skid is full: skid moves to main and skid_valid clears.
  - Order is strictly FIFO.
- Flush: next cycle, main and skid are both invalid, and an input presented in the Flush cycle is dropped. An output handshake in the Flush cycle still counts as delivered.

## Timing
- Reset (async, reset_n=0): out_valid=0, in_ready=1, SrcA=SrcB=0, ALUControl=000, RdOut=0, IllegalOp=0. Skid is empty.
- Latency: an input accepted at edge N appears on the outputs with out_valid=1 after edge N, i.e. in cycle N+1. Throughput is 1 per cycle when out_ready=1 continuously.
- out_ready low:
  - The first accepted item holds in main. A second item fills skid, after which in_ready=0 from the next cycle.
  - At most 2 items are buffered, and none are lost.
- Output stability: while out_valid=1 and out_ready=0, all data outputs stay constant.
- Simultaneous accept and drain with skid empty: the new item replaces main with no bubble.
- Reset asserted mid-stream: all state clears immediately and buffered items are lost. The first accept is possible at the first edge after reset_n rises.
- Data outputs when out_valid=0 are don't-care. Model them as holding their last value.

## Test plan
- Reset: hold reset_n=0 with random inputs -> out_valid=0, in_ready=1, all data outputs 0. Release, then send add x (RD1=5, RD2=7, Instr=0x00208033) -> next cycle out_valid=1, ALUControl=000, SrcA=5, SrcB=7, RdOut=0.
- Decode sweep: sub, sra, srai x1,x1,3 (Instr 0x4030D093), lui 0x12345, auipc with PC=0x100, sw, beq -> codes 001/110/110/000/000/000/001.
  - srai: SrcB=3.
  - lui: SrcA=0, SrcB=0x12345000.
  - auipc: SrcA=0x100.
- Illegal: slt, mul (funct7 0000001), blt, opcode 0x7F -> IllegalOp=1, ALUControl=000, SrcA=SrcB=0, one transaction each.
- Backpressure: out_ready=0, stream 3 instructions -> first two accepted, in_ready=0 at the third. Release -> outputs appear in order on consecutive cycles, then in_ready=1.
- Full throughput: 16 back-to-back adds with out_ready=1 -> 16 outputs on 16 consecutive cycles, in_ready never low.
- Flush: with 2 items buffered, assert Flush together with in_valid -> next cycle out_valid=0 and in_ready=1. Neither buffered item nor the incoming item ever appears.
